// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared types and constants for the RAM write/read controller
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  localparam int          CNT_W       = 24;
  localparam logic [23:0] CNT_MAX_DEF = 24'd9_999_999;
  localparam int          SEED_W      = 8;

endpackage

// File: rtl/dwell_cnt.sv
// rtl/dwell_cnt.sv - dwell counter with enable, clear and terminal-count flag
module dwell_cnt
  import ram_ctrl_pkg::*;
#(
  parameter logic [CNT_W-1:0] CNT_MAX = CNT_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == CNT_MAX);

  // Clear takes priority so a restart never inherits a partial dwell.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_wr_ctrl.sv
// rtl/ram_wr_ctrl.sv - fills a single-port RAM with a seeded pattern, then reads it back slowly
module ram_wr_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter logic [CNT_W-1:0] CNT_MAX = CNT_MAX_DEF,
  parameter int               ADDR_W  = 8,
  parameter int               DATA_W  = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              key1,
  input  logic              key2,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_done
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SEED_W-1:0]   seed_q, seed_d;
  logic                paused_q, paused_d;
  logic                wr_done_q, wr_done_d;
  logic                key1_q, key2_q;
  logic                cnt_en, cnt_clr, cnt_tc;
  logic [DATA_W-1:0]   seed_rep, addr_ext;

  // Keys pass through one register so no key-to-output path exists.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key1_q <= 1'b0;
      key2_q <= 1'b0;
    end else begin
      key1_q <= key1;
      key2_q <= key2;
    end
  end

  assign cnt_en  = (state_q == READ) && !paused_q && !key1_q;
  assign cnt_clr = (state_q != READ) || key1_q;

  dwell_cnt #(.CNT_MAX(CNT_MAX)) u_dwell (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    seed_d    = seed_q;
    paused_d  = paused_q;
    wr_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (key1_q) begin
          state_d = WRITE;
          addr_d  = '0;
        end
      end
      WRITE: begin
        if (addr_q == ADDR_LAST) begin
          state_d   = READ;
          addr_d    = '0;
          wr_done_d = 1'b1;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      READ: begin
        if (key1_q) begin
          state_d  = WRITE;
          addr_d   = '0;
          paused_d = 1'b0;
          seed_d   = seed_q + 1'b1;
        end else begin
          if (key2_q) paused_d = !paused_q;
          if (cnt_en && cnt_tc) addr_d = addr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      seed_q    <= '0;
      paused_q  <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      seed_q    <= seed_d;
      paused_q  <= paused_d;
      wr_done_q <= wr_done_d;
    end
  end

  // The 8-bit seed is repeated across the data word, truncated when narrower.
  for (genvar i = 0; i < DATA_W; i++) begin : g_seed
    assign seed_rep[i] = seed_q[i % SEED_W];
  end

  assign addr_ext = DATA_W'(addr_q);

  assign wr_en   = (state_q == WRITE);
  assign rd_en   = (state_q == READ) && !paused_q;
  assign addr    = addr_q;
  assign wr_data = (state_q == WRITE) ? (addr_ext ^ seed_rep) : '0;
  assign wr_done = wr_done_q;

endmodule
